// File: rtl/gs_raw_signal_source.sv
// gs_raw_signal_source: host-commanded capture of N 16-bit samples into a FIFO,
// served to the Xillybus read stream with EOF once all N samples have drained.
// Optional GS_RAW_SEQ_HEADER_EN: prefix each capture with a {8'hA5, seq} header word.
module gs_raw_signal_source #(
  parameter int FIFO_AW = 10,
  parameter int CNT_W   = 16
) (
  input  logic        bus_clk,
  input  logic        bus_rst,
  input  logic        user_w_gs_start_test_wren,
  input  logic [31:0] user_w_gs_start_test_data,
  output logic        user_w_gs_start_test_full,
  input  logic        user_w_gs_start_test_open,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  input  logic        user_r_gs_raw_signal_rden,
  output logic [15:0] user_r_gs_raw_signal_data,
  output logic        user_r_gs_raw_signal_empty,
  output logic        user_r_gs_raw_signal_eof,
  input  logic        user_r_gs_raw_signal_open,
  output logic        capture_busy,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_CNT = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DRAIN   = 2'd2,
    S_EOF     = 2'd3
  } state_t;

  state_t state, state_nxt;

  // FIFO storage and bookkeeping
  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count, count_nxt;
  logic               empty_q;
  logic [15:0]        rd_data;
  logic               fifo_full;

  // Capture control
  logic [CNT_W-1:0] n_target;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] cnt_plus;
  logic             ovf_q;

  // Decoded actions for this cycle
  logic        pop;
  logic        push;
  logic [15:0] push_dat;
  logic        start;
  logic        flush;
  logic        ovf_set;
  logic        ovf_clr;
  logic        cnt_inc;

  // Command bits above the count field other than bit 31 carry no meaning here.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^user_w_gs_start_test_data[30:CNT_W];

`ifdef GS_RAW_SEQ_HEADER_EN
  logic [7:0] seq;
`endif

  assign pop       = user_r_gs_raw_signal_rden & ~empty_q;
  assign fifo_full = (count == DEPTH_CNT);
  assign cnt_plus  = sample_cnt + 1'b1;

  // Next-state decode and per-cycle FIFO / counter actions
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_dat  = sample_data;
    start     = 1'b0;
    flush     = 1'b0;
    ovf_set   = 1'b0;
    ovf_clr   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        // full is low here, so every wren is consumed
        if (user_w_gs_start_test_wren) begin
          ovf_clr = user_w_gs_start_test_data[31];
          if (user_r_gs_raw_signal_open &&
              (user_w_gs_start_test_data[CNT_W-1:0] != '0)) begin
            start     = 1'b1;
            state_nxt = S_CAPTURE;
`ifdef GS_RAW_SEQ_HEADER_EN
            // FIFO is empty in IDLE, so the header always fits and leads the stream
            push      = 1'b1;
            push_dat  = {8'hA5, seq};
`endif
          end
        end
      end
      S_CAPTURE: begin
        if (!user_r_gs_raw_signal_open) begin
          flush     = 1'b1;
          state_nxt = S_IDLE;
        end else if (sample_valid) begin
          // the counter tracks samples offered, stored or not
          cnt_inc = 1'b1;
          if (!fifo_full || pop) begin
            push = 1'b1;
          end else begin
            ovf_set = 1'b1;
          end
          if (cnt_plus == n_target) begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!user_r_gs_raw_signal_open) begin
          flush     = 1'b1;
          state_nxt = S_IDLE;
        end else if (count == '0) begin
          state_nxt = S_EOF;
        end
      end
      S_EOF: begin
        if (!user_r_gs_raw_signal_open) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // State register
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FIFO pointers, count and registered empty; abort flush empties in one cycle
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty_q <= 1'b1;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty_q <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count   <= count_nxt;
      empty_q <= (count_nxt == '0);
    end
  end

  // FIFO storage write; a push at full with a pop reuses the slot being read
  always_ff @(posedge bus_clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Read data register: updates only on an accepted pop and holds otherwise
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      rd_data <= '0;
    end else if (pop) begin
      rd_data <= mem[rd_ptr];
    end
  end

  // Capture length, sample counter and sticky overflow
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      n_target   <= '0;
      sample_cnt <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (start) begin
        n_target   <= user_w_gs_start_test_data[CNT_W-1:0];
        sample_cnt <= '0;
      end else if (cnt_inc) begin
        sample_cnt <= cnt_plus;
      end
      if (ovf_clr) begin
        ovf_q <= 1'b0;
      end else if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

`ifdef GS_RAW_SEQ_HEADER_EN
  // Capture sequence number, advanced on every accepted start
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      seq <= '0;
    end else if (start) begin
      seq <= seq + 1'b1;
    end
  end
`endif

  assign user_w_gs_start_test_full  = (state != S_IDLE);
  assign user_r_gs_raw_signal_data  = rd_data;
  assign user_r_gs_raw_signal_empty = empty_q;
  assign user_r_gs_raw_signal_eof   = (state == S_EOF);
  assign capture_busy               = (state == S_CAPTURE) || (state == S_DRAIN);
  assign overflow                   = ovf_q;

endmodule
